// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling,
// and sticky ready / frame-error / overrun flags cleared by a one-cycle pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_uart_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_data_rdy,
  input  logic       i_data_rdy_clr,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      data_n;
  logic            sync_meta, sync_line, line_prev;
  logic            fall;
  logic            rdy_set, fe_set, ov_set;

  // Synchronizer and previous-sample flops idle high so reset never looks like a start edge.
  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_meta <= i_uart_rx;
      sync_line <= sync_meta;
      line_prev <= sync_line;
    end
  end

  assign fall = line_prev & ~sync_line;

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_data_rdy  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_data      <= data_n;
      // A flag event beats a simultaneous clear.
      o_data_rdy  <= rdy_set | (o_data_rdy  & ~i_data_rdy_clr);
      o_frame_err <= fe_set  | (o_frame_err & ~i_data_rdy_clr);
      o_overrun   <= ov_set  | (o_overrun   & ~i_data_rdy_clr);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = o_data;
    rdy_set   = 1'b0;
    fe_set    = 1'b0;
    ov_set    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = HALF_BIT;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (sync_line) begin
          state_n = IDLE;
        end else begin
          state_n   = DATA;
          cnt_n     = FULL_BIT;
          bit_idx_n = 3'd0;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n   = {sync_line, shift[7:1]};
          cnt_n     = FULL_BIT;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (sync_line) begin
          data_n  = shift;
          rdy_set = 1'b1;
          ov_set  = o_data_rdy;
          state_n = IDLE;
        end else begin
          fe_set  = 1'b1;
          state_n = WAIT_IDLE;
        end
      end
      // A held-low line (break) must return high before another start is accepted.
      WAIT_IDLE: begin
        if (sync_line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: directed and randomized frames against a flag/data reference model.
module tb_uart_rx;

  localparam int N       = 16;
  localparam int LATENCY = 3 + N / 2 + 9 * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       rdy, fe, ov, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic       m_rdy, m_ov, m_fe;

  int   k_rdy;
  logic busy_at_rdy, busy_before_rdy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .i_uart_clk    (clk),
    .i_reset_n     (rst_n),
    .i_uart_rx     (rx),
    .o_data        (data),
    .o_data_rdy    (rdy),
    .i_data_rdy_clr(clr),
    .o_frame_err   (fe),
    .o_overrun     (ov),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
  endfunction

  function automatic void model_clr();
    m_rdy = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (m_rdy) m_ov = 1'b1;
      m_data = b;
      m_rdy  = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".data"}, 32'(data), 32'(m_data));
    check({tag, ".rdy"},  32'(rdy),  32'(m_rdy));
    check({tag, ".ovr"},  32'(ov),   32'(m_ov));
    check({tag, ".ferr"}, 32'(fe),   32'(m_fe));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clr();
  endtask

  // Drives one frame starting at the current negedge; k counts elapsed clocks from the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int clr_at, input int abort_at);
    logic [9:0] fr;
    int         k;
    logic       rdy_prev, busy_prev;
    fr = {stop_val, b, 1'b0};
    k = 0;
    k_rdy = -1;
    rdy_prev = rdy;
    busy_prev = busy;
    busy_at_rdy = 1'b1;
    busy_before_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      for (int j = 0; j < N; j++) begin
        if (k == clr_at) clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        k++;
        if (rdy && !rdy_prev && k_rdy < 0) begin
          k_rdy = k;
          busy_at_rdy = busy;
          busy_before_rdy = busy_prev;
        end
        rdy_prev = rdy;
        busy_prev = busy;
        if (k == abort_at) return;
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic       saw_busy;
    logic [7:0] b;
    logic       good;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.data", 32'(data), 32'h0);
    check("rst.rdy",  32'(rdy),  32'h0);
    check("rst.ferr", 32'(fe),   32'h0);
    check("rst.ovr",  32'(ov),   32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Single byte and its latency
    send_frame(8'h5A, 1'b1, -1, -1);
    model_frame(8'h5A, 1'b1);
    check("5a.latency",     32'(k_rdy),           32'(LATENCY));
    check("5a.busy_at_rdy", 32'(busy_at_rdy),     32'h0);
    check("5a.busy_before", 32'(busy_before_rdy), 32'h1);
    check_model("5a");

    // Clear, then back-to-back frames producing overrun
    pulse_clr();
    check_model("clr1");
    send_frame(8'hA5, 1'b1, -1, -1);
    model_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1, -1, -1);
    model_frame(8'h00, 1'b1);
    check_model("b2b");
    idle(3);
    pulse_clr();
    check_model("clr2");

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("glitch.busy_pulse", 32'(saw_busy), 32'h1);
    check("glitch.busy_end",   32'(busy),     32'h0);
    check_model("glitch");

    // Frame error followed by a held-low line
    send_frame(8'hFF, 1'b0, -1, -1);
    model_frame(8'hFF, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr.busy_low", 32'(busy), 32'h1);
    check_model("ferr");
    rx = 1'b1;
    @(negedge clk);
    check("ferr.busy_hold", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    check("ferr.busy_release", 32'(busy), 32'h0);
    idle(4);
    send_frame(8'h3C, 1'b1, -1, -1);
    model_frame(8'h3C, 1'b1);
    check_model("after_ferr");

    // Reset mid-frame during data bit 4
    idle(3);
    send_frame(8'h81, 1'b1, -1, 5 * N + N / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("midrst.data", 32'(data), 32'h0);
    check("midrst.rdy",  32'(rdy),  32'h0);
    check("midrst.ferr", 32'(fe),   32'h0);
    check("midrst.ovr",  32'(ov),   32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(5);
    send_frame(8'h42, 1'b1, -1, -1);
    model_frame(8'h42, 1'b1);
    check_model("after_rst");

    // Clear coinciding with the stop-bit sample
    idle(2);
    pulse_clr();
    check_model("clr3");
    send_frame(8'h96, 1'b1, LATENCY - 1, -1);
    model_frame(8'h96, 1'b1);
    check_model("set_wins");

    // Randomized frames, gaps, errors and clears
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, -1, -1);
      model_frame(b, good);
      if (!good) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      check_model($sformatf("rnd%0d", n));
      if (good) idle($urandom_range(0, 3));
      else idle(6 + $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check_model($sformatf("rnd%0d.clr", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
